// File: rtl/matrix_scan_pkg.sv
// Shared types and helpers for the BCM panel scan generator.
package matrix_scan_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SHIFT   = 3'd1,
      S_BLANK   = 3'd2,
      S_LATCH   = 3'd3,
      S_DISPLAY = 3'd4
   } scan_state_e;

   // On-time of plane b: brightness scaled to the plane's display length, /256, truncated.
   // The 32-bit intermediate covers unit_shift + plane + 8 bits for all practical panels.
   function automatic logic [31:0] on_cycles(input logic [7:0] brightness,
                                             input int unsigned plane,
                                             input int unsigned unit_shift);
      logic [31:0] wide_s;
      wide_s = {24'd0, brightness} << (unit_shift + plane);
      return wide_s >> 8;
   endfunction

endpackage

// File: rtl/matrix_scan_bcm_display_timer.sv
// DISPLAY-phase counter: runs 2^(UNIT_SHIFT+plane) cycles and gates output-enable by the plane's on-time.
module bcm_display_timer
   import matrix_scan_pkg::*;
#(
   parameter int unsigned BIT_DEPTH  = 6,
   parameter int unsigned UNIT_SHIFT = 2,
   parameter int unsigned PLANE_W    = 3
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               start_i,
   input  logic [PLANE_W-1:0] plane_i,
   input  logic [7:0]         brightness_i,
   output logic               output_enable_o,
   output logic               done_o
);

   localparam int unsigned DW = UNIT_SHIFT + BIT_DEPTH;

   logic [DW-1:0] count_q;
   logic [DW-1:0] count_d;
   logic [DW-1:0] last_s;
   logic [DW-1:0] on_s;
   logic          running_q;
   logic          oe_q;

   always_comb begin
      count_d = count_q + DW'(1);
      last_s  = (DW'(1) << (UNIT_SHIFT + 32'(plane_i))) - DW'(1);
      on_s    = DW'(on_cycles(brightness_i, 32'(plane_i), UNIT_SHIFT));
   end

   // OE is registered so it lines up with the count it belongs to.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q   <= '0;
         running_q <= 1'b0;
         oe_q      <= 1'b0;
      end else if (start_i) begin
         count_q   <= '0;
         running_q <= 1'b1;
         oe_q      <= (on_s != '0);
      end else if (running_q && (count_q == last_s)) begin
         count_q   <= '0;
         running_q <= 1'b0;
         oe_q      <= 1'b0;
      end else if (running_q) begin
         count_q   <= count_d;
         oe_q      <= (count_d < on_s);
      end else begin
         oe_q      <= 1'b0;
      end
   end

   assign output_enable_o = oe_q;
   assign done_o          = running_q && (count_q == last_s);

endmodule

// File: rtl/matrix_scan_bcm.sv
// HUB75 scan generator: shifts one row per bit plane, blanks, latches, then displays with BCM timing.
module matrix_scan_bcm
   import matrix_scan_pkg::*;
#(
   parameter int unsigned COLUMN_WIDTH = 6,
   parameter int unsigned ROW_WIDTH    = 4,
   parameter int unsigned BIT_DEPTH    = 6,
   parameter int unsigned UNIT_SHIFT   = 2,
   parameter int unsigned BLANK_CYCLES = 2
) (
   input  logic                    clk_in,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [7:0]              global_brightness,
   output logic [COLUMN_WIDTH-1:0] column_address,
   output logic [ROW_WIDTH-1:0]    row_address,
   output logic [ROW_WIDTH-1:0]    row_address_active,
   output logic                    pixel_load_start,
   output logic                    clk_pixel,
   output logic                    row_latch,
   output logic                    output_enable,
   output logic [BIT_DEPTH-1:0]    brightness_mask,
   output logic                    frame_done
);

   localparam int unsigned PLANE_W = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1;
   localparam int unsigned BLANK_W = $clog2(BLANK_CYCLES + 1);
   localparam logic [COLUMN_WIDTH-1:0] LAST_COL   = '1;
   localparam logic [ROW_WIDTH-1:0]    LAST_ROW   = '1;
   localparam logic [PLANE_W-1:0]      LAST_PLANE = PLANE_W'(BIT_DEPTH - 1);
   localparam logic [BLANK_W-1:0]      LAST_BLANK = BLANK_W'(BLANK_CYCLES - 1);

   scan_state_e             state_q;
   logic [COLUMN_WIDTH-1:0] col_q;
   logic [ROW_WIDTH-1:0]    row_q;
   logic [ROW_WIDTH-1:0]    row_d;
   logic [ROW_WIDTH-1:0]    row_active_q;
   logic [PLANE_W-1:0]      plane_q;
   logic [PLANE_W-1:0]      plane_d;
   logic [BLANK_W-1:0]      blank_q;
   logic [7:0]              brightness_q;
   logic [BIT_DEPTH-1:0]    mask_q;
   logic                    phase_q;
   logic                    pls_q;
   logic                    clkp_q;
   logic                    latch_q;
   logic                    fd_q;
   logic                    frame_end_s;
   logic                    timer_start_s;
   logic                    timer_done_s;

   // Next plane/row after the current DISPLAY; row wraps naturally at its width.
   always_comb begin
      if (plane_q == LAST_PLANE) begin
         plane_d = '0;
         row_d   = row_q + ROW_WIDTH'(1);
      end else begin
         plane_d = plane_q + PLANE_W'(1);
         row_d   = row_q;
      end
      frame_end_s   = (plane_q == LAST_PLANE) && (row_q == LAST_ROW);
      timer_start_s = (state_q == S_LATCH);
   end

   // Scan FSM; every output register is loaded with the value for the state being entered.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q      <= S_IDLE;
         col_q        <= '0;
         row_q        <= '0;
         row_active_q <= '0;
         plane_q      <= '0;
         blank_q      <= '0;
         brightness_q <= 8'd0;
         mask_q       <= '0;
         phase_q      <= 1'b0;
         pls_q        <= 1'b0;
         clkp_q       <= 1'b0;
         latch_q      <= 1'b0;
         fd_q         <= 1'b0;
      end else begin
         pls_q   <= 1'b0;
         clkp_q  <= 1'b0;
         latch_q <= 1'b0;
         fd_q    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (enable) begin
                  state_q      <= S_SHIFT;
                  brightness_q <= global_brightness;
                  col_q        <= '0;
                  row_q        <= '0;
                  plane_q      <= '0;
                  phase_q      <= 1'b0;
                  mask_q       <= BIT_DEPTH'(1);
                  pls_q        <= 1'b1;
               end
            end
            S_SHIFT: begin
               if (!phase_q) begin
                  phase_q <= 1'b1;
                  clkp_q  <= 1'b1;
               end else if (col_q == LAST_COL) begin
                  phase_q <= 1'b0;
                  blank_q <= '0;
                  state_q <= S_BLANK;
               end else begin
                  phase_q <= 1'b0;
                  col_q   <= col_q + COLUMN_WIDTH'(1);
                  pls_q   <= 1'b1;
               end
            end
            S_BLANK: begin
               if (blank_q == LAST_BLANK) begin
                  state_q <= S_LATCH;
                  latch_q <= 1'b1;
               end else begin
                  blank_q <= blank_q + BLANK_W'(1);
               end
            end
            S_LATCH: begin
               row_active_q <= row_q;
               state_q      <= S_DISPLAY;
            end
            S_DISPLAY: begin
               if (timer_done_s && enable) begin
                  state_q <= S_SHIFT;
                  col_q   <= '0;
                  phase_q <= 1'b0;
                  plane_q <= plane_d;
                  row_q   <= row_d;
                  mask_q  <= BIT_DEPTH'(1) << plane_d;
                  pls_q   <= 1'b1;
                  if (frame_end_s) begin
                     fd_q         <= 1'b1;
                     brightness_q <= global_brightness;
                  end
               end else if (timer_done_s) begin
                  state_q <= S_IDLE;
                  col_q   <= '0;
                  row_q   <= '0;
                  plane_q <= '0;
                  mask_q  <= '0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   bcm_display_timer #(
      .BIT_DEPTH  (BIT_DEPTH),
      .UNIT_SHIFT (UNIT_SHIFT),
      .PLANE_W    (PLANE_W)
   ) u_timer (
      .clk_i           (clk_in),
      .reset_i         (reset),
      .start_i         (timer_start_s),
      .plane_i         (plane_q),
      .brightness_i    (brightness_q),
      .output_enable_o (output_enable),
      .done_o          (timer_done_s)
   );

   assign column_address     = col_q;
   assign row_address        = row_q;
   assign row_address_active = row_active_q;
   assign pixel_load_start   = pls_q;
   assign clk_pixel          = clkp_q;
   assign row_latch          = latch_q;
   assign brightness_mask    = mask_q;
   assign frame_done         = fd_q;

endmodule

// File: tb/tb_matrix_scan_bcm.sv
// Randomised bench for matrix_scan_bcm against a plane-timeline reference model.
module tb_matrix_scan_bcm;

   localparam int NCOL = 4;
   localparam int NROW = 2;
   localparam int BD   = 2;
   localparam int US   = 1;
   localparam int BLK  = 1;

   logic       clk_in = 1'b0;
   logic       reset;
   logic       enable;
   logic [7:0] gb;
   logic [1:0] col;
   logic [0:0] row;
   logic [0:0] ra;
   logic       pls;
   logic       clkp;
   logic       lat;
   logic       oe;
   logic [1:0] mask;
   logic       fd;

   int n_checks = 0;
   int n_fail   = 0;

   matrix_scan_bcm #(
      .COLUMN_WIDTH (2),
      .ROW_WIDTH    (1),
      .BIT_DEPTH    (2),
      .UNIT_SHIFT   (1),
      .BLANK_CYCLES (1)
   ) dut (
      .clk_in             (clk_in),
      .reset              (reset),
      .enable             (enable),
      .global_brightness  (gb),
      .column_address     (col),
      .row_address        (row),
      .row_address_active (ra),
      .pixel_load_start   (pls),
      .clk_pixel          (clkp),
      .row_latch          (lat),
      .output_enable      (oe),
      .brightness_mask    (mask),
      .frame_done         (fd)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: position t within the current plane's timeline.
   int m_run = 0, m_row = 0, m_plane = 0, m_t = 0, m_bq = 0, m_ra = 0, m_fd = 0;

   function automatic int plane_len(input int p);
      return 2 * NCOL + BLK + 1 + (1 << (US + p));
   endfunction

   task automatic model_step();
      if (reset) begin
         m_run = 0; m_bq = 0; m_ra = 0; m_fd = 0; m_row = 0; m_plane = 0; m_t = 0;
      end else if (m_run == 0) begin
         m_fd = 0;
         if (enable) begin
            m_run = 1; m_row = 0; m_plane = 0; m_t = 0; m_bq = int'(gb);
         end
      end else begin
         m_fd = 0;
         if (m_t == 2 * NCOL + BLK) m_ra = m_row;
         if (m_t == plane_len(m_plane) - 1) begin
            m_t = 0;
            if (!enable) begin
               m_run = 0; m_row = 0; m_plane = 0;
            end else if (m_plane == BD - 1) begin
               m_plane = 0;
               if (m_row == NROW - 1) begin
                  m_fd = 1;
                  m_bq = int'(gb);
               end
               m_row = (m_row + 1) % NROW;
            end else begin
               m_plane++;
            end
         end else begin
            m_t++;
         end
      end
   endtask

   task automatic compare();
      int e_col = 0, e_row = 0, e_pls = 0, e_clk = 0, e_lat = 0, e_oe = 0, e_mask = 0, on;
      if (m_run != 0) begin
         e_row  = m_row;
         e_mask = 1 << m_plane;
         e_col  = (m_t < 2 * NCOL) ? m_t / 2 : NCOL - 1;
         e_pls  = int'((m_t < 2 * NCOL) && (m_t % 2 == 0));
         e_clk  = int'((m_t < 2 * NCOL) && (m_t % 2 == 1));
         e_lat  = int'(m_t == 2 * NCOL + BLK);
         on     = (m_bq * (1 << (US + m_plane))) / 256;
         e_oe   = int'((m_t > 2 * NCOL + BLK) && (m_t - (2 * NCOL + BLK + 1) < on));
      end
      chk("column_address", int'(col), e_col);
      chk("row_address", int'(row), e_row);
      chk("row_address_active", int'(ra), m_ra);
      chk("pixel_load_start", int'(pls), e_pls);
      chk("clk_pixel", int'(clkp), e_clk);
      chk("row_latch", int'(lat), e_lat);
      chk("output_enable", int'(oe), e_oe);
      chk("brightness_mask", int'(mask), e_mask);
      chk("frame_done", int'(fd), m_fd);
   endtask

   // Hand-computed OE-high cycles per frame: sum over rows and planes of (br<<(1+b))>>8.
   function automatic int oe_per_frame(input int br);
      case (br)
         0:       return 0;
         64:      return 2;
         128:     return 6;
         255:     return 8;
         default: return -1;
      endcase
   endfunction

   int fr_cnt = 0, fr_oe = 0, fr_lat = 0, fr_pls = 0, fr_br = 0, fr_clean = 0;

   always begin
      @(posedge clk_in);
      model_step();
      #1;
      compare();
      if (reset || !enable) fr_clean = 0;
      if (fd) begin
         if (fr_clean != 0) begin
            chk("frame_length", fr_cnt, 52);
            chk("frame_latches", fr_lat, 4);
            chk("frame_load_strobes", fr_pls, 16);
            if (oe_per_frame(fr_br) >= 0) chk("frame_oe_cycles", fr_oe, oe_per_frame(fr_br));
         end
         fr_cnt = 0; fr_oe = 0; fr_lat = 0; fr_pls = 0;
         fr_br = int'(gb);
         fr_clean = int'(!reset && enable);
      end
      fr_cnt++;
      fr_oe  += int'(oe);
      fr_lat += int'(lat);
      fr_pls += int'(pls);
   end

   int waited;
   int r;

   initial begin
      reset  = 1'b1;
      enable = 1'b1;
      gb     = 8'd255;
      repeat (3) begin
         @(negedge clk_in);
         chk("reset_outputs_zero", int'({col, row, ra, pls, clkp, lat, oe, mask, fd}), 0);
      end
      reset = 1'b0;
      @(negedge clk_in);
      chk("first_load_strobe", int'(pls), 1);
      chk("first_column", int'(col), 0);
      chk("first_mask", int'(mask), 1);

      repeat (160) @(negedge clk_in);
      gb = 8'd128;
      repeat (160) @(negedge clk_in);
      gb = 8'd255;
      repeat (130) @(negedge clk_in);
      gb = 8'd0;
      repeat (160) @(negedge clk_in);
      gb = 8'd64;
      repeat (120) @(negedge clk_in);

      // Drop enable while shifting; the plane must finish and the scan must park.
      waited = 0;
      while (!pls && waited < 60) begin
         @(negedge clk_in);
         waited++;
      end
      chk("found_shift_before_drop", int'(pls), 1);
      enable = 1'b0;
      waited = 0;
      while (mask != 2'd0 && waited < 40) begin
         @(negedge clk_in);
         waited++;
      end
      chk("idle_after_enable_drop", int'(mask == 2'd0 && waited <= 14), 1);
      repeat (5) @(negedge clk_in);
      chk("idle_strobes_zero", int'({pls, clkp, lat, oe, fd}), 0);
      enable = 1'b1;
      @(negedge clk_in);
      chk("restart_load_strobe", int'(pls), 1);
      chk("restart_row", int'(row), 0);
      chk("restart_mask", int'(mask), 1);

      for (int i = 0; i < 3000; i++) begin
         @(negedge clk_in);
         r = int'($urandom_range(0, 999));
         reset = 1'b0;
         if (r < 2) reset = 1'b1;
         else if (r < 6 && enable) enable = 1'b0;
         else if (!enable && r < 60) enable = 1'b1;
         if (r >= 985) begin
            case ($urandom_range(0, 4))
               0:       gb = 8'd0;
               1:       gb = 8'd64;
               2:       gb = 8'd128;
               3:       gb = 8'd255;
               default: gb = 8'($urandom_range(0, 255));
            endcase
         end
      end
      reset = 1'b0;
      @(negedge clk_in);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/matrix_scan_bcm.md
# matrix_scan_bcm

Parametrised successor to the panel scan generator for HUB75-style LED matrices. Produces column/row addressing, pixel-load strobes, pixel clock, row latch and output-enable for a panel of 2^COLUMN_WIDTH columns and 2^ROW_WIDTH scan rows. It drives binary-coded-modulation (BCM) colour of BIT_DEPTH bit planes, with a run-time global brightness and a start/stop enable. It sits between the root clock domain and the framebuffer fetch and pixel-split logic at the top level.

## Interface
- COLUMN_WIDTH, 6, log2 of columns shifted per row
- ROW_WIDTH, 4, log2 of scan rows (row pairs on a 1:16 panel)
- BIT_DEPTH, 6, bit planes per colour channel
- UNIT_SHIFT, 2, log2 of display cycles for plane 0 (LSB)
- BLANK_CYCLES, 2, cycles OE is held low before each latch (≥1)

Ports:
- clk_in  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  run request
- global_brightness  in  8  OE duty scaling, sampled at frame start
- column_address  out  COLUMN_WIDTH  column currently being shifted
- row_address  out  ROW_WIDTH  row currently being shifted (fetch address)
- row_address_active  out  ROW_WIDTH  row currently displayed (panel A–D)
- pixel_load_start  out  1  one-cycle strobe per column to the fetch controller
- clk_pixel  out  1  panel shift clock
- row_latch  out  1  panel latch pulse
- output_enable  out  1  active-high; top level inverts it for the panel
- brightness_mask  out  BIT_DEPTH  one-hot, current plane, LSB = plane 0
- frame_done  out  1  one-cycle pulse at end of frame

## Operation
- States: IDLE, SHIFT, BLANK, LATCH, DISPLAY.
- IDLE: all outputs 0. Go to SHIFT when enable=1, with row=0 and plane b=0. Latch global_brightness into brightness_q.
- SHIFT: each column c=0..2^COLUMN_WIDTH-1 takes 2 cycles:
  - phase L: clk_pixel=0, pixel_load_start=1, column_address=c.
  - phase H: clk_pixel=1, pixel_load_start=0.
  - After the H phase of the last column, go to BLANK.
- brightness_mask=1<<b for the whole plane. row_address=current row.
- BLANK: output_enable=0 for BLANK_CYCLES cycles, then go to LATCH.
- LATCH: one cycle with row_latch=1. row_address_active takes row_address on the next edge. Then go to DISPLAY.
- DISPLAY: counter d runs 0..(2^(UNIT_SHIFT+b))-1.
  - output_enable=1 iff d < on_b, where on_b = (brightness_q << (UNIT_SHIFT+b)) >> 8.
  - Compute on_b with a UNIT_SHIFT+BIT_DEPTH+8-bit intermediate; no multiplier.
- End of DISPLAY:
  - If b < BIT_DEPTH-1: b+1, go to SHIFT on the same row.
  - Otherwise: b=0, row+1 (wraps modulo 2^ROW_WIDTH), go to SHIFT.
- Frame end is the last plane of row 2^ROW_WIDTH-1:
  - frame_done=1 for one cycle, on the cycle SHIFT of row 0 begins.
  - brightness_q is reloaded on that same cycle.
- enable is sampled only at the end of DISPLAY. If it is 0, go to IDLE: OE=0, counters cleared, row_address_active held.
- global_brightness changes mid-frame have no effect until the next frame.
- brightness_q=0: OE never asserts. brightness_q=255: OE low only for the last 2^(UNIT_SHIFT+b)/256 fraction, truncated.

## Timing
- Reset values: every output 0, state IDLE, brightness_q=0. Reset mid-operation returns to IDLE on the next edge.
- Cycles per plane b: 2·2^COLUMN_WIDTH + BLANK_CYCLES + 1 + 2^(UNIT_SHIFT+b).
- Defaults, plane 0: 128+2+1+4 = 135.
- Fetch latency budget: pixel data must be valid at the rising edge of clk_pixel, one clk_in cycle after pixel_load_start.
- output_enable is 0 from the first SHIFT cycle through LATCH. There is no display overlap with shifting.
- The row_latch cycle never coincides with output_enable=1.

## Structure
- Package matrix_scan_pkg holds:
  - the state enum;
  - a function on_cycles(brightness, b) returning on_b.
- Sub-module bcm_display_timer implements the DISPLAY counter and OE comparison.
  - Inputs: start, plane, brightness_q.
  - Outputs: output_enable, done.
- The scan FSM, column, plane and row counters stay in matrix_scan_bcm.

## Test plan
Bench parameters: COLUMN_WIDTH=2, ROW_WIDTH=1, BIT_DEPTH=2, UNIT_SHIFT=1, BLANK_CYCLES=1.
- Reset held 3 cycles, enable=1 → all outputs 0 during reset. The first pixel_load_start comes 1 cycle after reset release, with column_address=0.
- One plane, brightness 255 → 4 load strobes (columns 0,1,2,3) and 4 clk_pixel highs. OE=0 for 1 cycle, row_latch for 1 cycle, then OE=1 for 1 cycle and OE=0 for 1 cycle (on_0=(255<<1)>>8=1 of 2). Plane total 8+1+1+2=12 cycles.
- Plane 1 at brightness 128 → brightness_mask=2'b10; OE high 2 of 4 display cycles.
- Full frame, brightness 255 → frame_done is a single pulse every 12+14+12+14=52 cycles. row_address_active goes 0→1→0 on the cycles after the latches.
- brightness changed 255→0 mid-frame → OE duty unchanged until frame_done, then OE never asserts.
- enable dropped during SHIFT → current plane completes, then IDLE with all strobes 0. Re-assert → restarts at row 0, plane 0.
